// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the host holding register and the UART transmitter.
// Registered head byte, registered status flags and one-cycle error pulses.
module uart_tx_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              we_n,
    input  logic              re_n,
    output logic [WIDTH-1:0]  dout,
    output logic              empty,
    output logic              full,
    output logic [AWIDTH:0]   count,
    output logic              overflow,
    output logic              underflow
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   count_next;
    logic              wa;
    logic              ra;

    // A write is refused whenever full, even if a read frees a slot this cycle.
    assign wa = !we_n && !full;
    assign ra = !re_n && !empty;

    always_comb begin
        count_next = count;
        if (wa && !ra)
            count_next = count + 1'b1;
        else if (ra && !wa)
            count_next = count - 1'b1;
    end

    // Storage is not reset; contents are only meaningful through count.
    always_ff @(posedge clk) begin
        if (wa && !flush)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dout      <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            // dout deliberately keeps the last byte handed to the transmitter.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wa)
                wr_ptr <= wr_ptr + 1'b1;
            if (ra) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_next;
            empty     <= (count_next == '0);
            full      <= (count_next == (AWIDTH+1)'(DEPTH));
            overflow  <= !we_n && full;
            underflow <= !re_n && empty;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: queue-based reference model compared every
// cycle, plus literal expectations at key points of each scenario.
module tb_uart_tx_fifo;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int AWIDTH = 4;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] wdata = '0;
    logic             we_n  = 1'b1;
    logic             re_n  = 1'b1;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic [AWIDTH:0]  count;
    logic             overflow;
    logic             underflow;

    uart_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AWIDTH(AWIDTH)) dut (
        .clk(clk), .reset(reset), .flush(flush), .wdata(wdata),
        .we_n(we_n), .re_n(re_n), .dout(dout), .empty(empty), .full(full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit run = 0;

    // Reference model: a plain queue of stored bytes plus the last byte read.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;
    bit               m_fl;
    bit               m_em;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else if (flush) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_fl  = (q.size() == DEPTH);
            m_em  = (q.size() == 0);
            m_ovf = !we_n && m_fl;
            m_unf = !re_n && m_em;
            if (!re_n && !m_em)
                m_dout = q.pop_front();
            if (!we_n && !m_fl)
                q.push_back(wdata);
        end
    end

    always @(negedge clk) begin
        if (run && !reset) begin
            chk("dout",      32'(dout),      32'(m_dout));
            chk("count",     32'(count),     32'(q.size()));
            chk("empty",     32'(empty),     32'(q.size() == 0));
            chk("full",      32'(full),      32'(q.size() == DEPTH));
            chk("overflow",  32'(overflow),  32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
        end
    end

    // One clock: drive at a falling edge, return at the next falling edge.
    task automatic cyc(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit f);
        we_n  = !w;
        wdata = d;
        re_n  = !r;
        flush = f;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run   = 1'b1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full",  32'(full),  0);
        chk("rst_dout",  32'(dout),  0);

        // Reads on an empty FIFO
        for (int i = 0; i < 3; i++) begin
            cyc(0, 8'h00, 1, 0);
            chk("idle_underflow", 32'(underflow), 1);
            chk("idle_dout",      32'(dout),      0);
        end
        cyc(0, 8'h00, 0, 0);
        chk("idle_underflow_end", 32'(underflow), 0);

        // Two bytes in, two bytes out
        cyc(1, 8'hA5, 0, 0);
        chk("wr1_empty", 32'(empty), 0);
        chk("wr1_count", 32'(count), 1);
        cyc(1, 8'h3C, 0, 0);
        chk("wr2_count", 32'(count), 2);
        cyc(0, 8'h00, 1, 0);
        chk("rd1_dout",  32'(dout),  32'h A5);
        chk("rd1_count", 32'(count), 1);
        cyc(0, 8'h00, 1, 0);
        chk("rd2_dout",  32'(dout),  32'h3C);
        chk("rd2_count", 32'(count), 0);
        chk("rd2_empty", 32'(empty), 1);
        cyc(0, 8'h00, 0, 0);

        // Fill, overflow, drain
        for (int i = 0; i < DEPTH; i++)
            cyc(1, 8'(i), 0, 0);
        chk("fill_full",  32'(full),  1);
        chk("fill_count", 32'(count), 16);
        cyc(1, 8'hFF, 0, 0);
        chk("ovf_pulse", 32'(overflow), 1);
        chk("ovf_count", 32'(count),    16);
        cyc(0, 8'h00, 0, 0);
        chk("ovf_clear", 32'(overflow), 0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 8'h00, 1, 0);
            chk("drain_dout", 32'(dout), 32'(i));
        end
        chk("drain_empty", 32'(empty), 1);
        cyc(0, 8'h00, 0, 0);

        // Simultaneous read and write while full
        for (int i = 0; i < DEPTH; i++)
            cyc(1, 8'(8'h10 + i), 0, 0);
        cyc(1, 8'h55, 1, 0);
        chk("fullrw_dout",  32'(dout),     32'h10);
        chk("fullrw_ovf",   32'(overflow), 1);
        chk("fullrw_count", 32'(count),    15);
        chk("fullrw_full",  32'(full),     0);
        for (int i = 1; i < DEPTH; i++)
            cyc(0, 8'h00, 1, 0);
        chk("fullrw_last", 32'(dout), 32'h1F);
        cyc(0, 8'h00, 0, 0);

        // Streaming across pointer wrap, level held at 2
        for (int i = 0; i < 40; i++) begin
            cyc(1, 8'(8'h80 + i), i >= 2, 0);
            chk("wrap_level_le3", 32'(count <= 3), 1);
            chk("wrap_no_err",    32'(overflow | underflow), 0);
            if (i >= 2)
                chk("wrap_dout", 32'(dout), 32'(8'h80 + i - 2));
        end
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        chk("wrap_tail", 32'(dout), 32'hA7);
        chk("wrap_empty", 32'(empty), 1);

        // Flush with a concurrent write
        for (int i = 0; i < 5; i++)
            cyc(1, 8'(8'hC0 + i), 0, 0);
        cyc(1, 8'hEE, 0, 1);
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_dout",  32'(dout),  32'hA7);
        cyc(1, 8'h11, 0, 0);
        cyc(0, 8'h00, 1, 0);
        chk("post_flush_dout", 32'(dout), 32'h11);
        cyc(0, 8'h00, 0, 0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++)
            cyc(1, 8'(8'hD0 + i), 0, 0);
        cyc(0, 8'h00, 1, 0);
        we_n = 1'b1;
        re_n = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_full",  32'(full),  0);
        chk("arst_dout",  32'(dout),  0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 8'h77, 0, 0);
        chk("arst_wr_count", 32'(count), 1);
        cyc(0, 8'h00, 1, 0);
        chk("arst_rd_dout", 32'(dout), 32'h77);
        cyc(0, 8'h00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
